hbus_mi_arbiter: RTL

//  Shares one hbus_memctrl memory interface (mi_*) between N requesters.

---
 rtl/hbus_mi_arbiter_pkg.sv | 18 +
 rtl/hbus_mi_arbiter_if.sv | 56 +++++
 rtl/hbus_mi_arbiter_rr_pick.sv | 42 ++++
 rtl/hbus_mi_arbiter.sv | 101 ++++++++++
 4 files changed

// File: rtl/hbus_mi_arbiter_pkg.sv
// Shared definitions for the hbus memory-interface arbiter: FSM states and
// per-port field widths used by the interface, the picker and the top level.
package hbus_mi_arbiter_pkg;

   localparam int CS_W   = 2;
   localparam int ADDR_W = 32;
   localparam int LEN_W  = 7;
   localparam int DATA_W = 32;
   localparam int MSK_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_WR   = 2'd2,
      ST_RD   = 2'd3
   } arb_state_t;

endpackage

// File: rtl/hbus_mi_arbiter_if.sv
// Bundles the N client ports (req_*) and the single memctrl port (mi_*).
// The slave modport is the arbiter's view; master is the surrounding system's.
interface hbus_mi_arbiter_if #(
   parameter int N = 4
);
   import hbus_mi_arbiter_pkg::*;

   logic [CS_W*N-1:0]   req_addr_cs;
   logic [ADDR_W*N-1:0] req_addr;
   logic [LEN_W*N-1:0]  req_len;
   logic [N-1:0]        req_rw;
   logic [N-1:0]        req_linear;
   logic [N-1:0]        req_valid;
   logic [N-1:0]        req_ready;
   logic [DATA_W*N-1:0] req_wdata;
   logic [MSK_W*N-1:0]  req_wmsk;
   logic [N-1:0]        req_wack;
   logic [N-1:0]        req_wlast;
   logic [DATA_W-1:0]   req_rdata;
   logic [N-1:0]        req_rstb;
   logic [N-1:0]        req_rlast;

   logic [CS_W-1:0]     mi_addr_cs;
   logic [ADDR_W-1:0]   mi_addr;
   logic [LEN_W-1:0]    mi_len;
   logic                mi_rw;
   logic                mi_linear;
   logic                mi_valid;
   logic                mi_ready;
   logic [DATA_W-1:0]   mi_wdata;
   logic [MSK_W-1:0]    mi_wmsk;
   logic                mi_wack;
   logic                mi_wlast;
   logic [DATA_W-1:0]   mi_rdata;
   logic                mi_rstb;
   logic                mi_rlast;

   modport slave (
      input  req_addr_cs, req_addr, req_len, req_rw, req_linear, req_valid,
      input  req_wdata, req_wmsk,
      output req_ready, req_wack, req_wlast, req_rdata, req_rstb, req_rlast,
      output mi_addr_cs, mi_addr, mi_len, mi_rw, mi_linear, mi_valid,
      output mi_wdata, mi_wmsk,
      input  mi_ready, mi_wack, mi_wlast, mi_rdata, mi_rstb, mi_rlast
   );

   modport master (
      output req_addr_cs, req_addr, req_len, req_rw, req_linear, req_valid,
      output req_wdata, req_wmsk,
      input  req_ready, req_wack, req_wlast, req_rdata, req_rstb, req_rlast,
      input  mi_addr_cs, mi_addr, mi_len, mi_rw, mi_linear, mi_valid,
      input  mi_wdata, mi_wmsk,
      output mi_ready, mi_wack, mi_wlast, mi_rdata, mi_rstb, mi_rlast
   );

endinterface

// File: rtl/hbus_mi_arbiter_rr_pick.sv
// hbus_rr_pick: combinational round-robin winner search starting after 'last'.
// HBUS_ARB_HIPRIO_EN makes port 0 win outright and leaves 'last' untouched for it.
module hbus_rr_pick #(
   parameter int N  = 4,
   parameter int NW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [NW-1:0] last,
   output logic          gnt_vld,
   output logic [NW-1:0] gnt_idx,
   output logic          upd_last
);

   // First requester found walking last+1 .. last+N (mod N) wins.
   always_comb begin
      gnt_vld  = 1'b0;
      gnt_idx  = '0;
      upd_last = 1'b0;
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (int'(last) + k) % N;
`ifdef HBUS_ARB_HIPRIO_EN
         if (!gnt_vld && idx != 0 && req[idx]) begin
`else
         if (!gnt_vld && req[idx]) begin
`endif
            gnt_vld  = 1'b1;
            gnt_idx  = idx[NW-1:0];
            upd_last = 1'b1;
         end
      end
`ifdef HBUS_ARB_HIPRIO_EN
      // Port 0 pre-empts the rotation without disturbing its position.
      if (req[0]) begin
         gnt_vld  = 1'b1;
         gnt_idx  = '0;
         upd_last = 1'b0;
      end
`endif
   end

endmodule

// File: rtl/hbus_mi_arbiter.sv
// hbus_mi_arbiter: shares one memctrl interface between N requesters with a
// per-command round-robin grant. Optional feature macro: HBUS_ARB_HIPRIO_EN.
module hbus_mi_arbiter #(
   parameter int N = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   hbus_mi_arbiter_if.slave        bus,
   output logic [$clog2(N)-1:0]    arb_owner,
   output logic                    arb_busy
);
   import hbus_mi_arbiter_pkg::*;

   localparam int NW = $clog2(N);

   arb_state_t    state, state_nxt;
   logic [NW-1:0] owner;
   logic [NW-1:0] rr_last;
   logic          gnt_vld;
   logic [NW-1:0] gnt_idx;
   logic          upd_last;
   logic          mi_valid_d;
   logic [N-1:0]  ready_d, wack_d, wlast_d, rstb_d, rlast_d;

   hbus_rr_pick #(.N(N), .NW(NW)) u_pick (
      .req      (bus.req_valid),
      .last     (rr_last),
      .gnt_vld  (gnt_vld),
      .gnt_idx  (gnt_idx),
      .upd_last (upd_last)
   );

   // Grant is registered in ST_IDLE; ownership then holds until the last beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         owner   <= '0;
         rr_last <= NW'(N - 1);
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && gnt_vld) begin
            owner <= gnt_idx;
            if (upd_last) rr_last <= gnt_idx;
         end
      end
   end

   // Next state plus the owner-only strobe demux.
   always_comb begin
      state_nxt  = state;
      mi_valid_d = 1'b0;
      ready_d    = '0;
      wack_d     = '0;
      wlast_d    = '0;
      rstb_d     = '0;
      rlast_d    = '0;
      case (state)
         ST_IDLE: begin
            if (gnt_vld) state_nxt = ST_CMD;
         end
         ST_CMD: begin
            mi_valid_d     = bus.req_valid[owner];
            ready_d[owner] = bus.req_valid[owner] & bus.mi_ready;
            if (!bus.req_valid[owner]) state_nxt = ST_IDLE;
            else if (bus.mi_ready)     state_nxt = bus.req_rw[owner] ? ST_RD : ST_WR;
         end
         ST_WR: begin
            wack_d[owner]  = bus.mi_wack;
            wlast_d[owner] = bus.mi_wlast;
            if (bus.mi_wack && bus.mi_wlast) state_nxt = ST_IDLE;
         end
         ST_RD: begin
            rstb_d[owner]  = bus.mi_rstb;
            rlast_d[owner] = bus.mi_rlast & bus.mi_rstb;
            if (bus.mi_rstb && bus.mi_rlast) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Write data is muxed combinationally because memctrl samples it alongside wack.
   assign bus.mi_addr_cs = bus.req_addr_cs[owner*CS_W +: CS_W];
   assign bus.mi_addr    = bus.req_addr[owner*ADDR_W +: ADDR_W];
   assign bus.mi_len     = bus.req_len[owner*LEN_W +: LEN_W];
   assign bus.mi_rw      = bus.req_rw[owner];
   assign bus.mi_linear  = bus.req_linear[owner];
   assign bus.mi_valid   = mi_valid_d;
   assign bus.mi_wdata   = bus.req_wdata[owner*DATA_W +: DATA_W];
   assign bus.mi_wmsk    = bus.req_wmsk[owner*MSK_W +: MSK_W];

   assign bus.req_ready  = ready_d;
   assign bus.req_wack   = wack_d;
   assign bus.req_wlast  = wlast_d;
   assign bus.req_rstb   = rstb_d;
   assign bus.req_rlast  = rlast_d;
   assign bus.req_rdata  = bus.mi_rdata;

   assign arb_owner = owner;
   assign arb_busy  = (state != ST_IDLE);

endmodule
